// File: rtl/sp_ram_arb_init.sv
// Two-master round-robin front-end for a single-port RAM. The RAM is zero-filled
// after every reset before any grant; responses follow one cycle after the grant.
module sp_ram_arb_init #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INIT_EN    = 1,
  parameter int unsigned INIT_WORDS = 8192
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,
  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  output logic                    init_done_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = (INIT_WORDS > 1) ? $clog2(INIT_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

  state_t                  state_r;
  state_t                  state_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    ptr_r;
  logic                    ptr_s;
  logic                    gnt0_s;
  logic                    gnt1_s;
  logic                    rvalid0_r;
  logic                    rvalid1_r;
  logic                    rd_r;
  logic                    init_done_r;
  logic [ADDR_WIDTH-1:0]   fill_addr_s;
  logic                    ram_en_s;
  logic [ADDR_WIDTH-1:0]   ram_addr_s;
  logic                    ram_we_s;
  logic [BE_WIDTH-1:0]     ram_be_s;
  logic [DATA_WIDTH-1:0]   ram_wdata_s;

  // Next state, fill address and round-robin grant selection
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    fill_addr_s = {ADDR_WIDTH{1'b0}};
    fill_addr_s[CNT_W+1:2] = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == CNT_LAST) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_INIT;
        end
      end
      ST_RUN: begin
        // The pointer only moves when both ports compete
        if (p0_req_i && p1_req_i) begin
          gnt0_s = ~ptr_r;
          gnt1_s = ptr_r;
          ptr_s  = ~ptr_r;
        end else if (p0_req_i) begin
          gnt0_s = 1'b1;
        end else if (p1_req_i) begin
          gnt1_s = 1'b1;
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      end
      default: begin
        state_s = RST_STATE;
      end
    endcase
  end

  // RAM port mux: fill writes, granted master, or fully idle
  always_comb begin
    ram_en_s    = 1'b0;
    ram_addr_s  = {ADDR_WIDTH{1'b0}};
    ram_we_s    = 1'b0;
    ram_be_s    = {BE_WIDTH{1'b0}};
    ram_wdata_s = {DATA_WIDTH{1'b0}};
    if (state_r == ST_INIT) begin
      ram_en_s    = 1'b1;
      ram_addr_s  = fill_addr_s;
      ram_we_s    = 1'b1;
      ram_be_s    = {BE_WIDTH{1'b1}};
    end else if (gnt0_s) begin
      ram_en_s    = 1'b1;
      ram_addr_s  = p0_addr_i & ALIGN_MASK;
      ram_we_s    = p0_we_i;
      ram_be_s    = p0_be_i;
      ram_wdata_s = p0_wdata_i;
    end else if (gnt1_s) begin
      ram_en_s    = 1'b1;
      ram_addr_s  = p1_addr_i & ALIGN_MASK;
      ram_we_s    = p1_we_i;
      ram_be_s    = p1_be_i;
      ram_wdata_s = p1_wdata_i;
    end else begin
      ram_en_s    = 1'b0;
    end
  end

  // State, fill counter, pointer and one-cycle response registers
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_r     <= RST_STATE;
      cnt_r       <= {CNT_W{1'b0}};
      ptr_r       <= 1'b0;
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
      rd_r        <= 1'b0;
      init_done_r <= (INIT_EN == 0);
    end else begin
      state_r     <= state_s;
      ptr_r       <= ptr_s;
      if ((state_r == ST_INIT) && (cnt_r != CNT_LAST)) begin
        cnt_r <= cnt_r + 1'b1;
      end
      rvalid0_r   <= gnt0_s;
      rvalid1_r   <= gnt1_s;
      rd_r        <= (gnt0_s & ~p0_we_i) | (gnt1_s & ~p1_we_i);
      init_done_r <= (state_s == ST_RUN);
    end
  end

  assign p0_gnt_o    = gnt0_s;
  assign p1_gnt_o    = gnt1_s;
  assign p0_rvalid_o = rvalid0_r;
  assign p1_rvalid_o = rvalid1_r;
  assign p0_rdata_o  = (rvalid0_r && rd_r) ? ram_rdata_i : {DATA_WIDTH{1'b0}};
  assign p1_rdata_o  = (rvalid1_r && rd_r) ? ram_rdata_i : {DATA_WIDTH{1'b0}};
  assign ram_en_o    = ram_en_s;
  assign ram_addr_o  = ram_addr_s;
  assign ram_we_o    = ram_we_s;
  assign ram_be_o    = ram_be_s;
  assign ram_wdata_o = ram_wdata_s;
  assign init_done_o = init_done_r;

endmodule

// File: tb/tb_sp_ram_arb_init.sv
// Scoreboard bench for sp_ram_arb_init: behavioural RAM, word-level reference memory,
// randomized and directed traffic, responses checked by an independent monitor.
module tb_sp_ram_arb_init;

  localparam int AW    = 15;
  localparam int DW    = 32;
  localparam int BW    = 4;
  localparam int WORDS = 8192;

  logic clk = 1'b0;
  logic rst_i;
  logic p0_req_i, p0_gnt_o, p0_we_i, p0_rvalid_o;
  logic [AW-1:0] p0_addr_i;
  logic [BW-1:0] p0_be_i;
  logic [DW-1:0] p0_wdata_i, p0_rdata_o;
  logic p1_req_i, p1_gnt_o, p1_we_i, p1_rvalid_o;
  logic [AW-1:0] p1_addr_i;
  logic [BW-1:0] p1_be_i;
  logic [DW-1:0] p1_wdata_i, p1_rdata_o;
  logic ram_en_o, ram_we_o, init_done_o;
  logic [AW-1:0] ram_addr_o;
  logic [BW-1:0] ram_be_o;
  logic [DW-1:0] ram_wdata_o, ram_rdata_i;

  sp_ram_arb_init #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1), .INIT_WORDS(WORDS)) dut (
    .clk(clk), .rst_i(rst_i),
    .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
    .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
    .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
    .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .init_done_o(init_done_o)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle read latency, seeded with non-zero garbage
  logic [DW-1:0] ram_mem [WORDS];
  logic seed_mem;
  always @(posedge clk) begin
    if (seed_mem) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < BW; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= ram_mem[ram_addr_o[AW-1:2]];
      end
    end
  end

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [WORDS];
  int            vectors = 0;
  int            miscompares = 0;
  logic          mon_en = 1'b0;
  int            fill_idx;
  int            rr;

  logic          op_req   [2];
  logic          op_we    [2];
  logic [AW-1:0] op_addr  [2];
  logic [BW-1:0] op_be    [2];
  logic [DW-1:0] op_wdata [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic new_op(input int p, input logic we, input logic [AW-1:0] addr,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd);
    op_req[p]   = 1'b1;
    op_we[p]    = we;
    op_addr[p]  = addr;
    op_be[p]    = be;
    op_wdata[p] = wd;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [12:0] wd;
    wd = ($urandom_range(0, 1) == 1) ? 13'h1FC0 : 13'h0040;
    wd = wd + 13'($urandom_range(0, 63));
    return {wd, 2'($urandom_range(0, 3))};
  endfunction

  // One clock cycle: drive at the falling edge, check combinational outputs 1 time unit later
  task automatic drive_cycle(input bit in_reset);
    int win;
    int w;
    logic [AW-1:0] a;
    rst_i = in_reset;
    p0_req_i = op_req[0]; p0_we_i = op_we[0]; p0_addr_i = op_addr[0];
    p0_be_i = op_be[0]; p0_wdata_i = op_wdata[0];
    p1_req_i = op_req[1]; p1_we_i = op_we[1]; p1_addr_i = op_addr[1];
    p1_be_i = op_be[1]; p1_wdata_i = op_wdata[1];
    #1;
    if (in_reset) begin
      fill_idx = 0;
      rr = 0;
      exp_q.delete();
    end else if (fill_idx >= 0) begin
      chk("fill_ctrl", {p1_gnt_o, p0_gnt_o, ram_en_o, ram_we_o, ram_be_o, init_done_o, ram_addr_o},
          {2'b00, 1'b1, 1'b1, 4'hF, 1'b0, 15'(fill_idx * 4)});
      chk("fill_wdata", ram_wdata_o, 64'd0);
      fill_idx++;
      if (fill_idx == WORDS) begin
        fill_idx = -1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'd0;
      end
    end else begin
      chk("init_done", init_done_o, 64'd1);
      win = -1;
      if (op_req[0] && op_req[1]) begin
        win = rr;
        rr = 1 - rr;
      end else if (op_req[0]) win = 0;
      else if (op_req[1]) win = 1;
      chk("gnt", {p1_gnt_o, p0_gnt_o}, {62'd0, win == 1, win == 0});
      if (win >= 0) begin
        a = op_addr[win];
        a[1:0] = 2'b00;
        w = int'(op_addr[win][AW-1:2]);
        chk("ram_req", {ram_en_o, ram_we_o, ram_be_o, ram_addr_o}, {1'b1, op_we[win], op_be[win], a});
        if (op_we[win]) begin
          chk("ram_wdata", ram_wdata_o, op_wdata[win]);
          for (int b = 0; b < BW; b++)
            if (op_be[win][b]) ref_mem[w][8*b +: 8] = op_wdata[win][8*b +: 8];
          exp_q.push_back('{port: win, data: 32'd0});
        end else begin
          exp_q.push_back('{port: win, data: ref_mem[w]});
        end
        op_req[win] = 1'b0;
      end else begin
        chk("ram_idle", {ram_en_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o}, 64'd0);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive_cycle(1'b1);
    for (int p = 0; p < 2; p++) op_req[p] = 1'b0;
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] addr,
                       input logic [BW-1:0] be, input logic [DW-1:0] wd);
    new_op(p, we, addr, be, wd);
    for (int k = 0; k < 20 && op_req[p]; k++) drive_cycle(1'b0);
    if (op_req[p]) begin
      chk("gnt_timeout", {63'd0, op_req[p]}, 64'd0);
      op_req[p] = 1'b0;
    end
  endtask

  // Response monitor: every rvalid must match the oldest outstanding grant
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (p0_rvalid_o === 1'b1 || p1_rvalid_o === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("rvalid_unexpected", {p1_rvalid_o, p0_rvalid_o}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("rvalid_port", {p1_rvalid_o, p0_rvalid_o}, (e.port == 1) ? 64'd2 : 64'd1);
            chk("rdata", (e.port == 1) ? p1_rdata_o : p0_rdata_o, e.data);
            chk("rdata_other", (e.port == 1) ? p0_rdata_o : p1_rdata_o, 64'd0);
          end
        end else begin
          chk("rdata_idle", {p1_rdata_o, p0_rdata_o}, 64'd0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rvalid_missing", {p1_rvalid_o, p0_rvalid_o}, (e.port == 1) ? 64'd2 : 64'd1);
          end
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    seed_mem = 1'b1;
    fill_idx = -1;
    rr = 0;
    for (int p = 0; p < 2; p++) new_op(p, 1'b0, 15'd0, 4'd0, 32'd0);
    op_req[0] = 1'b0;
    op_req[1] = 1'b0;
    p0_req_i = 1'b0; p1_req_i = 1'b0;
    @(negedge clk);
    seed_mem = 1'b0;
    mon_en = 1'b1;
    do_reset();

    // Full fill with both masters requesting and held off; then contested start
    new_op(0, 1'b1, 15'h0010, 4'hF, 32'h1111_1111);
    new_op(1, 1'b0, 15'h0010, 4'hF, 32'd0);
    repeat (WORDS) drive_cycle(1'b0);
    repeat (4) drive_cycle(1'b0);

    // Full and partial write with read-back
    issue(0, 1'b1, 15'h0104, 4'hF, 32'hDEAD_BEEF);
    issue(0, 1'b0, 15'h0104, 4'hF, 32'd0);
    issue(0, 1'b1, 15'h0104, 4'h2, 32'h0000_AA00);
    issue(0, 1'b0, 15'h0104, 4'hF, 32'd0);

    // Continuous contested reads
    for (int c = 0; c < 6; c++) begin
      for (int p = 0; p < 2; p++)
        if (!op_req[p]) new_op(p, 1'b0, rand_addr(), 4'hF, 32'd0);
      drive_cycle(1'b0);
    end
    op_req[0] = 1'b0;
    op_req[1] = 1'b0;

    // Misaligned read from port 1
    issue(1, 1'b0, 15'h0FFE, 4'hF, 32'd0);
    repeat (2) drive_cycle(1'b0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 2; p++)
        if (!op_req[p] && $urandom_range(0, 3) != 0)
          new_op(p, 1'($urandom_range(0, 1)), rand_addr(), 4'($urandom_range(1, 15)), $urandom);
      drive_cycle(1'b0);
    end
    for (int k = 0; k < 10 && (op_req[0] || op_req[1]); k++) drive_cycle(1'b0);
    repeat (3) drive_cycle(1'b0);
    chk("drain", exp_q.size(), 64'd0);

    // Reset mid-fill: fill restarts from word 0
    do_reset();
    repeat (100) drive_cycle(1'b0);
    do_reset();
    repeat (WORDS) drive_cycle(1'b0);
    drive_cycle(1'b0);

    // Move the pointer to port 1, then reset in the cycle of a port-0 read grant
    new_op(0, 1'b0, 15'h0200, 4'hF, 32'd0);
    new_op(1, 1'b0, 15'h0204, 4'hF, 32'd0);
    drive_cycle(1'b0);
    drive_cycle(1'b0);
    new_op(0, 1'b0, 15'h0104, 4'hF, 32'd0);
    do_reset();
    repeat (WORDS) drive_cycle(1'b0);
    new_op(0, 1'b0, 15'h0104, 4'hF, 32'd0);
    new_op(1, 1'b0, 15'h0104, 4'hF, 32'd0);
    repeat (4) drive_cycle(1'b0);
    chk("final_drain", exp_q.size(), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
